// File: rtl/keccak_byte_packer.sv
// -----------------------------------------------------------------------------
// keccak_byte_packer
//
// Upstream feeder for the keccak core. Collects a valid/ready byte stream,
// packs it big-endian into 32-bit words (first byte of a word in [31:24]) and
// drives the core's k_in / k_in_ready / k_is_last / k_byte_num protocol.
// Before every message the core is held in reset for KRESET_CYCLES cycles. The
// packer then waits for k_out_ready, so each core run digests exactly one
// message.
//
// Parameters
//   KRESET_CYCLES  cycles k_reset is held high before each message (1..15)
//
// Ports
//   clk            system clock, all state on the rising edge
//   reset          synchronous active-low reset (0 = reset)
//   s_byte/s_valid/s_last/s_ready   input byte stream
//   k_reset        active-high reset to the core (also high while reset=0)
//   k_in           word to the core, first byte in [31:24]
//   k_in_ready     k_in valid; a word moves when k_in_ready & ~k_buffer_full
//   k_is_last      final word of the message
//   k_byte_num     valid bytes in the final word (0..3)
//   k_buffer_full  core cannot take a word this cycle
//   k_out_ready    core digest valid
//   busy           packer is not idle
//   msg_done       one-cycle pulse once the digest of a message is ready
//   msg_len        (KECCAK_PACKER_LEN_EN only) bytes accepted for the
//                  current message, saturating at 16'hFFFF
//
// Build option
//   KECCAK_PACKER_LEN_EN  when defined, adds the msg_len output and counter.
// -----------------------------------------------------------------------------
module keccak_byte_packer #(
    parameter int KRESET_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        k_reset,
    output logic [31:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [1:0]  k_byte_num,
    input  logic        k_buffer_full,
    input  logic        k_out_ready,
    output logic        busy,
    output logic        msg_done
`ifdef KECCAK_PACKER_LEN_EN
    ,
    output logic [15:0] msg_len
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_FILL = 3'd2,
        ST_SEND = 3'd3,
        ST_TERM = 3'd4,
        ST_WAIT = 3'd5
    } state_e;

    // Last value of the core-reset cycle counter before moving on to FILL.
    localparam logic [3:0] RST_LAST = 4'(KRESET_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;            // byte position inside current word
    logic [31:0] sr_q, sr_d;              // partially assembled word
    logic [31:0] k_in_q, k_in_d;
    logic        term_q, term_d;          // message ended on a word boundary
    logic        k_is_last_q, k_is_last_d;
    logic [1:0]  k_byte_num_q, k_byte_num_d;
    logic        k_in_ready_q, k_in_ready_d;
    logic        s_ready_q, s_ready_d;
    logic        k_rst_q, k_rst_d;
    logic        busy_q, busy_d;
    logic        msg_done_q, msg_done_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
`ifdef KECCAK_PACKER_LEN_EN
    logic [15:0] len_q, len_d;
`endif

    logic        accept_s;                // byte handshake this cycle
    logic        xfer_s;                  // word handshake this cycle
    logic [31:0] word_s;                  // sr_q with the incoming byte merged

    assign accept_s = s_ready_q & s_valid;
    assign xfer_s   = k_in_ready_q & ~k_buffer_full;

    // Merge the incoming byte into its big-endian slot of the word under construction.
    always_comb begin
        word_s = sr_q;
        case (cnt_q)
            2'd0:    word_s[31:24] = s_byte;
            2'd1:    word_s[23:16] = s_byte;
            2'd2:    word_s[15:8]  = s_byte;
            2'd3:    word_s[7:0]   = s_byte;
            default: word_s        = sr_q;
        endcase
    end

    // Next-state and next-output computation for the packer FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        k_in_d       = k_in_q;
        term_d       = term_q;
        k_is_last_d  = k_is_last_q;
        k_byte_num_d = k_byte_num_q;
        rst_cnt_d    = rst_cnt_q;
        msg_done_d   = 1'b0;
`ifdef KECCAK_PACKER_LEN_EN
        len_d        = len_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // The byte that wakes us up is not consumed; it is taken in FILL.
                if (s_valid) begin
                    state_d   = ST_RST;
                    rst_cnt_d = 4'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_RST: begin
                cnt_d        = 2'd0;
                sr_d         = 32'd0;
                term_d       = 1'b0;
                k_is_last_d  = 1'b0;
                k_byte_num_d = 2'd0;
`ifdef KECCAK_PACKER_LEN_EN
                len_d        = 16'd0;
`endif
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_FILL;
                    rst_cnt_d = 4'd0;
                end else begin
                    state_d   = ST_RST;
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end

            ST_FILL: begin
                if (accept_s) begin
`ifdef KECCAK_PACKER_LEN_EN
                    if (len_q != 16'hFFFF) begin
                        len_d = len_q + 16'd1;
                    end else begin
                        len_d = len_q;
                    end
`endif
                    if (cnt_q == 2'd3) begin
                        // Full word. If it is also the end of the message the
                        // core still needs an empty terminating word (TERM).
                        k_in_d       = word_s;
                        k_is_last_d  = 1'b0;
                        k_byte_num_d = 2'd0;
                        term_d       = s_last;
                        sr_d         = 32'd0;
                        cnt_d        = 2'd0;
                        state_d      = ST_SEND;
                    end else if (s_last) begin
                        // Short final word; low bytes are still zero in sr_q.
                        k_in_d       = word_s;
                        k_is_last_d  = 1'b1;
                        k_byte_num_d = cnt_q + 2'd1;
                        term_d       = 1'b0;
                        sr_d         = 32'd0;
                        cnt_d        = 2'd0;
                        state_d      = ST_SEND;
                    end else begin
                        sr_d    = word_s;
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_SEND: begin
                if (xfer_s) begin
                    if (term_q) begin
                        state_d      = ST_TERM;
                        k_in_d       = 32'd0;
                        k_is_last_d  = 1'b1;
                        k_byte_num_d = 2'd0;
                        term_d       = 1'b0;
                    end else if (k_is_last_q) begin
                        state_d      = ST_WAIT;
                        k_in_d       = 32'd0;
                        k_is_last_d  = 1'b0;
                        k_byte_num_d = 2'd0;
                    end else begin
                        state_d = ST_FILL;
                        cnt_d   = 2'd0;
                        sr_d    = 32'd0;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_TERM: begin
                if (xfer_s) begin
                    state_d      = ST_WAIT;
                    k_is_last_d  = 1'b0;
                    k_byte_num_d = 2'd0;
                end else begin
                    state_d = ST_TERM;
                end
            end

            ST_WAIT: begin
                if (k_out_ready) begin
                    state_d    = ST_IDLE;
                    msg_done_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are decoded from the next state so they come
        // straight off flops and line up with the state they describe.
        s_ready_d    = (state_d == ST_FILL);
        k_in_ready_d = (state_d == ST_SEND) || (state_d == ST_TERM);
        k_rst_d      = (state_d == ST_RST);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            sr_q         <= 32'd0;
            k_in_q       <= 32'd0;
            term_q       <= 1'b0;
            k_is_last_q  <= 1'b0;
            k_byte_num_q <= 2'd0;
            k_in_ready_q <= 1'b0;
            s_ready_q    <= 1'b0;
            k_rst_q      <= 1'b0;
            busy_q       <= 1'b0;
            msg_done_q   <= 1'b0;
            rst_cnt_q    <= 4'd0;
`ifdef KECCAK_PACKER_LEN_EN
            len_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            k_in_q       <= k_in_d;
            term_q       <= term_d;
            k_is_last_q  <= k_is_last_d;
            k_byte_num_q <= k_byte_num_d;
            k_in_ready_q <= k_in_ready_d;
            s_ready_q    <= s_ready_d;
            k_rst_q      <= k_rst_d;
            busy_q       <= busy_d;
            msg_done_q   <= msg_done_d;
            rst_cnt_q    <= rst_cnt_d;
`ifdef KECCAK_PACKER_LEN_EN
            len_q        <= len_d;
`endif
        end
    end

    // The core follows the packer's own reset directly so it never runs
    // while the packer is being reset.
    assign k_reset    = ~reset | k_rst_q;
    assign s_ready    = s_ready_q;
    assign k_in       = k_in_q;
    assign k_in_ready = k_in_ready_q;
    assign k_is_last  = k_is_last_q;
    assign k_byte_num = k_byte_num_q;
    assign busy       = busy_q;
    assign msg_done   = msg_done_q;
`ifdef KECCAK_PACKER_LEN_EN
    assign msg_len    = len_q;
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for keccak_byte_packer. A message-level model turns each
// byte string into the list of words the core must receive; a monitor checks
// every transfer, the length of each k_reset pulse, stall stability and
// msg_done ordering. Directed messages plus randomized ones with gaps and
// back-pressure.
// -----------------------------------------------------------------------------
module tb_keccak_byte_packer;

    localparam int KR = 3;

    logic        clk;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        k_reset;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;
    logic        busy;
    logic        msg_done;
`ifdef KECCAK_PACKER_LEN_EN
    logic [15:0] msg_len;
`endif

    keccak_byte_packer #(.KRESET_CYCLES(KR)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_byte        (s_byte),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .k_reset       (k_reset),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .k_out_ready   (k_out_ready),
        .busy          (busy),
        .msg_done      (msg_done)
`ifdef KECCAK_PACKER_LEN_EN
        ,
        .msg_len       (msg_len)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] exp_w[$];
    logic        exp_l[$];
    logic [1:0]  exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic load(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    task automatic clear_model();
        exp_w.delete();
        exp_l.delete();
        exp_b.delete();
    endtask

    // Word list the core must see for the message in tx_q.
    task automatic model_push();
        int n;
        int full;
        int rem;
        logic [31:0] w;
        n    = tx_q.size();
        full = n / 4;
        rem  = n % 4;
        for (int k = 0; k < full; k++) begin
            exp_w.push_back({tx_q[4*k], tx_q[4*k+1], tx_q[4*k+2], tx_q[4*k+3]});
            exp_l.push_back(1'b0);
            exp_b.push_back(2'd0);
        end
        if (rem == 0) begin
            exp_w.push_back(32'd0);
            exp_l.push_back(1'b1);
            exp_b.push_back(2'd0);
        end else begin
            w = 32'd0;
            for (int j = 0; j < rem; j++) w = w | (32'(tx_q[4*full+j]) << (24 - 8*j));
            exp_w.push_back(w);
            exp_l.push_back(1'b1);
            exp_b.push_back(2'(rem));
        end
    endtask

    // Monitor: every negedge, check transfers and protocol rules.
    int          kr_run     = 0;
    bit          in_msg     = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_in;
    logic        prev_last;
    logic [1:0]  prev_bn;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("k_reset_during_reset", 32'(k_reset), 32'd1);
                kr_run     = 0;
                in_msg     = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (k_reset) begin
                    if (kr_run == 0) begin
                        chk("k_reset_only_between_msgs", 32'(in_msg), 32'd0);
                        in_msg = 1'b1;
                    end
                    kr_run++;
`ifdef KECCAK_PACKER_LEN_EN
                    chk("msg_len_in_rst", 32'(msg_len), 32'd0);
`endif
                end else if (kr_run != 0) begin
                    chk("k_reset_pulse_len", 32'(kr_run), 32'(KR));
                    kr_run = 0;
                end
                if (stall_prev) begin
                    chk("stall_hold_ready", 32'(k_in_ready), 32'd1);
                    chk("stall_hold_data", k_in, prev_in);
                    chk("stall_hold_last", 32'(k_is_last), 32'(prev_last));
                    chk("stall_hold_bnum", 32'(k_byte_num), 32'(prev_bn));
                end
                if (k_in_ready) begin
                    chk("s_ready_while_sending", 32'(s_ready), 32'd0);
                    if (exp_w.size() == 0) begin
                        chk("unexpected_word", 32'(k_in_ready), 32'd0);
                    end else if (!k_buffer_full) begin
                        chk("word_data", k_in, exp_w[0]);
                        chk("word_last", 32'(k_is_last), 32'(exp_l[0]));
                        chk("word_bnum", 32'(k_byte_num), 32'(exp_b[0]));
                        void'(exp_w.pop_front());
                        void'(exp_l.pop_front());
                        void'(exp_b.pop_front());
                    end
                end
                if (msg_done) begin
                    chk("done_inside_msg", 32'(in_msg), 32'd1);
                    chk("done_after_words", 32'(exp_w.size()), 32'd0);
                    in_msg = 1'b0;
                end
                stall_prev = k_in_ready && k_buffer_full;
                prev_in    = k_in;
                prev_last  = k_is_last;
                prev_bn    = k_byte_num;
            end
        end
    end

    // Send tx_q as one message. abort_after>0 resets the DUT after that many
    // accepted bytes. hold_valid keeps s_valid high through WAIT so the next
    // message is already requested when the digest arrives.
    task automatic run_msg(input int gap_pct, input int bf_pct, input bit stall_mode,
                           input int abort_after, input bit hold_valid);
        int n;
        int i;
        int cyc;
        int stall_cnt;
        int wait_n;
        bit aborted;
        n = tx_q.size();
        i = 0;
        cyc = 0;
        stall_cnt = 0;
        aborted = 1'b0;
        model_push();
        while ((i < n || exp_w.size() != 0) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (i < n) begin
                s_valid = ($urandom_range(99) >= 32'(gap_pct));
                s_byte  = tx_q[i];
                s_last  = (i == n - 1);
            end else begin
                s_valid = 1'b0;
                s_byte  = 8'd0;
                s_last  = 1'b0;
            end
            if (stall_mode) k_buffer_full = (stall_cnt < 7);
            else            k_buffer_full = ($urandom_range(99) < 32'(bf_pct));
            k_out_ready = ($urandom_range(99) < 32'd10);
            @(negedge clk); #1;
            if (stall_mode && k_in_ready && k_buffer_full) stall_cnt++;
            if (s_valid && s_ready) begin
                i++;
                if (i == abort_after) begin
                    aborted = 1'b1;
                    break;
                end
            end
        end
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL msg_timeout: actual=%0d accepted of %0d, %0d words left", i, n, exp_w.size());
            aborted = 1'b1;
        end
        if (aborted) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            k_out_ready = 1'b0;
            k_buffer_full = 1'b0;
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            clear_model();
            for (int c = 0; c < 5; c++) begin
                @(negedge clk); #1;
                chk("no_word_after_reset", 32'(k_in_ready), 32'd0);
                chk("idle_after_reset", 32'(busy), 32'd0);
            end
            return;
        end
        @(posedge clk); #1;
        k_out_ready   = 1'b0;
        k_buffer_full = 1'b0;
        s_valid = hold_valid;
        s_byte  = 8'hEE;
        s_last  = 1'b0;
        wait_n  = int'($urandom_range(3));
        for (int c = 0; c < wait_n; c++) begin
            @(negedge clk); #1;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_no_done", 32'(msg_done), 32'd0);
            chk("wait_in_ready", 32'(k_in_ready), 32'd0);
            chk("wait_is_last", 32'(k_is_last), 32'd0);
            chk("wait_byte_num", 32'(k_byte_num), 32'd0);
            @(posedge clk); #1;
        end
        k_out_ready = 1'b1;
        @(negedge clk); #1;
        chk("busy_before_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        k_out_ready = 1'b0;
        @(negedge clk); #1;
        chk("msg_done_pulse", 32'(msg_done), 32'd1);
        chk("busy_drops", 32'(busy), 32'd0);
`ifdef KECCAK_PACKER_LEN_EN
        chk("msg_len_done", 32'(msg_len), 32'(n));
`endif
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("msg_done_single", 32'(msg_done), 32'd0);
        chk("busy_next_msg", 32'(busy), 32'(hold_valid));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit hv;
        reset = 1'b0;
        s_valid = 1'b0;
        s_byte = 8'd0;
        s_last = 1'b0;
        k_buffer_full = 1'b0;
        k_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_k_in_ready", 32'(k_in_ready), 32'd0);
        chk("rst_k_is_last", 32'(k_is_last), 32'd0);
        chk("rst_k_byte_num", 32'(k_byte_num), 32'd0);
        chk("rst_k_in", k_in, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_msg_done", 32'(msg_done), 32'd0);
        chk("rst_k_reset", 32'(k_reset), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("idle_k_reset", 32'(k_reset), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Pin the model on hand-computed word lists.
        load("Hello, world!");
        model_push();
        chk("model_hello0", exp_w[0], 32'h48656C6C);
        chk("model_hello1", exp_w[1], 32'h6F2C2077);
        chk("model_hello3", exp_w[3], 32'h21000000);
        chk("model_hello3_bn", 32'(exp_b[3]), 32'd1);
        clear_model();
        load("Hello, world");
        model_push();
        chk("model_hello12_2", exp_w[2], 32'h6F726C64);
        chk("model_hello12_2_last", 32'(exp_l[2]), 32'd0);
        chk("model_hello12_term", exp_w[3], 32'h00000000);
        chk("model_hello12_term_last", 32'(exp_l[3]), 32'd1);
        clear_model();
        load("abc");
        model_push();
        chk("model_abc", exp_w[0], 32'h61626300);
        chk("model_abc_bn", 32'(exp_b[0]), 32'd3);
        clear_model();

        // Directed messages.
        load("Hello, world!");
        run_msg(0, 0, 1'b0, -1, 1'b0);
        load("Hello, world");
        run_msg(0, 0, 1'b0, -1, 1'b0);
        load("1234567890");
        run_msg(0, 0, 1'b1, -1, 1'b0);
        load("The quick");
        run_msg(0, 0, 1'b0, 6, 1'b0);
        load("abc");
        run_msg(0, 0, 1'b0, -1, 1'b0);
        load("abcd");
        run_msg(0, 0, 1'b0, -1, 1'b1);
        load("ef");
        run_msg(0, 0, 1'b0, -1, 1'b0);
        load("Hello, world!");
        run_msg(0, 0, 1'b0, -1, 1'b1);
        load("ab");
        run_msg(0, 0, 1'b0, -1, 1'b0);

        // Randomized messages with input gaps and core back-pressure.
        for (int m = 0; m < 25; m++) begin
            tx_q.delete();
            len = int'($urandom_range(1, 20));
            for (int b = 0; b < len; b++) tx_q.push_back(8'($urandom));
            hv = (m < 24) ? 1'($urandom_range(1)) : 1'b0;
            run_msg(30, 30, 1'b0, -1, hv);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
